// File: rtl/timer_mc_pkg.sv
// Shared constants for the multi-channel timer: register offsets, CTRL bit
// positions and reset values.
package timer_mc_pkg;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_CMP  = 2'd1,
    REG_PRE  = 2'd2,
    REG_CNT  = 2'd3
  } reg_e;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_CASCADE = 2;
  localparam int CTRL_IE      = 5;
  localparam int CTRL_EXP     = 6;
  localparam int CTRL_CLR     = 7;

  localparam logic [7:0] CTRL_RST    = 8'h00;
  localparam int         CMP_RST_DEF = 9;
  localparam int         PRE_RST     = 0;

endpackage

// File: rtl/timer_mc_if.sv
// Register port of the multi-channel timer; addr = {channel, reg[1:0]}.
interface timer_mc_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  localparam int ADDR_W = $clog2(NCH) + 2;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wdata;
  logic [CNT_W-1:0]  rdata;

  modport master (output read, write, addr, wdata, input rdata);
  modport slave  (input read, write, addr, wdata, output rdata);

endinterface

// File: rtl/timer_mc_ch.sv
// One timer channel: CTRL/CMP/PRE registers, prescaler, up-counter with compare,
// tout pulse and EXP status. CTRL.IE exists only when TIMER_MC_IRQ_EN is defined.
module timer_mc_ch
  import timer_mc_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PRE_W      = 4,
  parameter int CMP_RST    = CMP_RST_DEF,
  parameter bit CASCADE_OK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  reg_e             reg_sel,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] rd_data,
  input  logic             cascade_in,
  output logic             expire_out,
  output logic             tout,
  output logic             irq_req
);

  logic             start, oneshot, cascade, ie, exp;
  logic [CNT_W-1:0] cmp, cnt;
  logic [PRE_W-1:0] pre, pre_cnt;
  logic             tout_r;

  logic wr_ctrl, wr_cmp, wr_pre, clr;
  logic cascade_en, pre_hit, cnt_hit, tick, match;

  assign wr_ctrl    = wr_en && (reg_sel == REG_CTRL);
  assign wr_cmp     = wr_en && (reg_sel == REG_CMP);
  assign wr_pre     = wr_en && (reg_sel == REG_PRE);
  assign clr        = wr_ctrl && wdata[CTRL_CLR];
  assign cascade_en = CASCADE_OK && cascade;
  assign pre_hit    = (pre_cnt == pre);
  assign cnt_hit    = (cnt == cmp);
  assign tick       = start && (cascade_en ? cascade_in : pre_hit);
  // A clear owns the cycle it is written in, so it also swallows any match.
  assign match      = tick && !clr && cnt_hit;

  // NOTE: non-blocking (<=) for all state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start   <= CTRL_RST[CTRL_START];
      oneshot <= CTRL_RST[CTRL_ONESHOT];
      cascade <= CTRL_RST[CTRL_CASCADE];
      exp     <= CTRL_RST[CTRL_EXP];
      cmp     <= CNT_W'(CMP_RST);
      pre     <= PRE_W'(PRE_RST);
      pre_cnt <= '0;
      cnt     <= '0;
      tout_r  <= 1'b0;
    end else begin
      tout_r <= match;

      if (clr || cascade_en)
        pre_cnt <= '0;
      else if (start)
        pre_cnt <= pre_hit ? '0 : pre_cnt + PRE_W'(1);

      if (clr)
        cnt <= '0;
      else if (tick)
        cnt <= cnt_hit ? '0 : cnt + CNT_W'(1);

      if (match && oneshot)
        start <= 1'b0;

      if (wr_ctrl) begin
        start   <= wdata[CTRL_START];
        oneshot <= wdata[CTRL_ONESHOT];
        cascade <= wdata[CTRL_CASCADE];
        if (wdata[CTRL_EXP])
          exp <= 1'b0;
      end
      // Placed after the W1C so a simultaneous expiry keeps EXP set.
      if (match)
        exp <= 1'b1;

      if (wr_cmp)
        cmp <= wdata;
      if (wr_pre)
        pre <= wdata[PRE_W-1:0];
    end
  end

`ifdef TIMER_MC_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ie <= CTRL_RST[CTRL_IE];
    else if (wr_ctrl)
      ie <= wdata[CTRL_IE];
  end
`else
  assign ie = 1'b0;
`endif

  // NOTE: default assigned first so no path leaves rd_data unassigned (no latch).
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: rd_data[7:0] = {1'b0, exp, ie, 2'b00, cascade, oneshot, start};
      REG_CMP:  rd_data = cmp;
      REG_PRE:  rd_data[PRE_W-1:0] = pre;
      REG_CNT:  rd_data = cnt;
      default:  rd_data = '0;
    endcase
  end

  assign tout       = tout_r;
  assign expire_out = tout_r;
  assign irq_req    = exp & ie;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel programmable timer top: address decode, rdata mux, cascade chain
// and combined irq. Optional macro TIMER_MC_IRQ_EN enables CTRL.IE and irq.
module timer_mc
  import timer_mc_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int PRE_W   = 4,
  parameter int CMP_RST = CMP_RST_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  timer_mc_if.slave      bus,
  output logic [NCH-1:0] tout,
  output logic           irq
);

  localparam int ADDR_W = $clog2(NCH) + 2;
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CH_W-1:0]  ch_sel;
  reg_e             reg_sel;
  logic [CNT_W-1:0] ch_rd [NCH];
  logic [NCH-1:0]   expire, casc, irq_req;

  generate
    if (NCH > 1) begin : g_ch_sel
      assign ch_sel = bus.addr[ADDR_W-1:2];
    end else begin : g_ch_sel_one
      assign ch_sel = '0;
    end
  endgenerate

  assign reg_sel = reg_e'(bus.addr[1:0]);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    if (g == 0) begin : g_head
      assign casc[g] = 1'b0;
    end else begin : g_link
      assign casc[g] = expire[g-1];
    end

    timer_mc_ch #(
      .CNT_W     (CNT_W),
      .PRE_W     (PRE_W),
      .CMP_RST   (CMP_RST),
      .CASCADE_OK(g != 0)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (bus.write && (ch_sel == CH_W'(g))),
      .reg_sel   (reg_sel),
      .wdata     (bus.wdata),
      .rd_data   (ch_rd[g]),
      .cascade_in(casc[g]),
      .expire_out(expire[g]),
      .tout      (tout[g]),
      .irq_req   (irq_req[g])
    );
  end

  // Channel codes at or above NCH fall through the loop and read as zero.
  always_comb begin
    bus.rdata = '0;
    if (rst_n && bus.read) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_sel == CH_W'(i))
          bus.rdata = ch_rd[i];
      end
    end
  end

`ifdef TIMER_MC_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq <= 1'b0;
    else
      irq <= |irq_req;
  end
`else
  logic unused_irq_req;
  assign unused_irq_req = |irq_req;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_timer_mc.sv
// Scoreboard bench for timer_mc (NCH=3 so channel 3 is unmapped): reads and
// tout pulses are queued as expectations and checked by independent monitors.
module tb_timer_mc;
  import timer_mc_pkg::*;

  localparam int NCH    = 3;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = $clog2(NCH) + 2;
`ifdef TIMER_MC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef struct {
    string name;
    int    val;
  } rd_exp_t;

  typedef struct {
    int cyc;
    int mask;
  } pulse_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] tout;
  logic           irq;
  int             cyc   = 0;
  int             n_cmp = 0;
  int             n_bad = 0;
  int             k, m;

  rd_exp_t rd_q[$];
  pulse_t  pulse_q[$];
  rd_exp_t rd_e;
  pulse_t  pl;

  timer_mc_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  timer_mc #(
    .NCH    (NCH),
    .CNT_W  (CNT_W),
    .PRE_W  (4),
    .CMP_RST(9)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .tout (tout),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Read monitor: any cycle with read high must match the oldest queued value.
  always @(negedge clk) begin
    if (bus.read) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", int'(bus.rdata), -1);
      end else begin
        rd_e = rd_q.pop_front();
        check(rd_e.name, int'(bus.rdata), rd_e.val);
      end
    end
  end

  // Pulse monitor: every non-zero tout cycle must match the next queued pulse.
  always @(negedge clk) begin
    if (tout != '0) begin
      if (pulse_q.size() == 0) begin
        check("unexpected_tout", int'(tout), 0);
      end else begin
        pl = pulse_q.pop_front();
        check("tout_cycle", cyc, pl.cyc);
        check("tout_mask", int'(tout), pl.mask);
      end
    end
  end

  task automatic op(input bit do_rd, input bit do_wr, input int ch, input int r,
                    input int data, input int e, input string name);
    bus.addr  = ADDR_W'((ch << 2) | r);
    bus.wdata = CNT_W'(data);
    bus.read  = do_rd;
    bus.write = do_wr;
    if (do_rd) rd_q.push_back('{name, e});
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic wr(input int ch, input int r, input int data);
    op(1'b0, 1'b1, ch, r, data, 0, "");
  endtask

  task automatic rd(input int ch, input int r, input int e, input string name);
    op(1'b1, 1'b0, ch, r, 0, e, name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pulse(input int c, input int mask);
    pulse_q.push_back('{c, mask});
  endtask

  initial begin
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset defaults, rdata gating, read/write collision, unmapped channel.
    repeat (2) @(posedge clk);
    #1;
    rd(0, REG_CMP, 0, "rdata_in_reset");
    rst_n = 1'b1;
    rd(0, REG_CMP, 8'h09, "rst_cmp");
    rd(0, REG_CTRL, 8'h00, "rst_ctrl");
    rd(0, REG_CNT, 8'h00, "rst_cnt");
    rd(1, REG_PRE, 8'h00, "rst_pre");
    check("rst_irq", int'(irq), 0);
    op(1'b1, 1'b1, 2, REG_CMP, 8'h20, 8'h09, "rw_prewrite");
    rd(2, REG_CMP, 8'h20, "cmp_written");
    wr(0, REG_CNT, 8'h33);
    rd(0, REG_CNT, 8'h00, "cnt_readonly");
    wr(3, REG_CMP, 8'h55);
    rd(3, REG_CMP, 8'h00, "unmapped_ch");

    // Periodic ch0: expiry every 10 clk, EXP W1C.
    wr(0, REG_PRE, 0);
    wr(0, REG_CMP, 9);
    k = cyc;
    push_pulse(k + 11, 1);
    push_pulse(k + 21, 1);
    push_pulse(k + 31, 1);
    wr(0, REG_CTRL, 8'h01);
    idle(32);
    rd(0, REG_CTRL, 8'h41, "periodic_exp");
    rd(0, REG_CNT, 8'h03, "periodic_cnt");
    wr(0, REG_CTRL, 8'h41);
    rd(0, REG_CTRL, 8'h01, "exp_w1c");
    wr(0, REG_CTRL, 8'hC0);
    rd(0, REG_CNT, 8'h00, "stop_clr_cnt");
    check("periodic_done", pulse_q.size(), 0);
    check("periodic_irq", int'(irq), 0);

    // Prescaled one-shot ch1: single pulse 20 clk after start.
    wr(1, REG_PRE, 3);
    wr(1, REG_CMP, 4);
    k = cyc;
    push_pulse(k + 21, 2);
    wr(1, REG_CTRL, 8'h03);
    idle(24);
    rd(1, REG_CTRL, 8'h42, "oneshot_stopped");
    idle(20);
    rd(1, REG_CNT, 8'h00, "oneshot_cnt");
    check("oneshot_done", pulse_q.size(), 0);

    // Cascade: ch1 counts ch0 expiries, period 100 clk.
    wr(1, REG_CMP, 9);
    wr(1, REG_CTRL, 8'h05);
    k = cyc;
    for (int j = 0; j < 20; j++) begin
      push_pulse(k + 11 + 10 * j, 1);
      if (j == 9 || j == 19) push_pulse(k + 12 + 10 * j, 2);
    end
    wr(0, REG_CTRL, 8'h01);
    idle(204);
    wr(0, REG_CTRL, 8'hC0);
    wr(1, REG_CTRL, 8'hC0);
    idle(4);
    check("cascade_done", pulse_q.size(), 0);

    // Pause holds CNT; CLR+START restarts from zero (cascade bit ignored on ch0).
    k = cyc;
    wr(0, REG_CTRL, 8'h01);
    idle(4);
    wr(0, REG_CTRL, 8'h00);
    idle(20);
    rd(0, REG_CNT, 8'h05, "pause_hold");
    m = cyc;
    push_pulse(m + 11, 1);
    wr(0, REG_CTRL, 8'h85);
    rd(0, REG_CNT, 8'h00, "clr_start_cnt");
    rd(0, REG_CTRL, 8'h05, "clr_selfclear");
    idle(10);
    wr(0, REG_CTRL, 8'hC0);
    check("pause_done", pulse_q.size(), 0);

    // CMP=0 boundary on ch2: expiry on every tick (PRE=1 -> every 2 clk).
    wr(2, REG_PRE, 1);
    wr(2, REG_CMP, 0);
    k = cyc;
    push_pulse(k + 3, 4);
    push_pulse(k + 5, 4);
    push_pulse(k + 7, 4);
    wr(2, REG_CTRL, 8'h01);
    idle(6);
    wr(2, REG_CTRL, 8'hC0);
    wr(2, REG_PRE, 0);
    check("cmp0_done", pulse_q.size(), 0);

    // IRQ on ch2; W1C coinciding with expiry leaves EXP set.
    wr(2, REG_CMP, 2);
    k = cyc;
    push_pulse(k + 4, 4);
    push_pulse(k + 7, 4);
    wr(2, REG_CTRL, 8'h21);
    idle(3);
    check("irq_at_first_tout", int'(irq), 0);
    idle(1);
    check("irq_rise", int'(irq), int'(IRQ_EN));
    idle(1);
    wr(2, REG_CTRL, 8'h61);
    rd(2, REG_CTRL, IRQ_EN ? 8'h61 : 8'h41, "exp_set_wins");
    check("irq_held", int'(irq), int'(IRQ_EN));
    wr(2, REG_CTRL, 8'hC0);
    idle(2);
    check("irq_cleared", int'(irq), 0);
    check("irq_done", pulse_q.size(), 0);

    // Reset asserted one cycle before an expiry: no pulse, state zeroed.
    k = cyc;
    wr(0, REG_CTRL, 8'h01);
    idle(9);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    rd(0, REG_CNT, 8'h00, "midreset_cnt");
    rd(2, REG_CMP, 8'h09, "midreset_cmp");
    rd(0, REG_CTRL, 8'h00, "midreset_ctrl");
    check("midreset_irq", int'(irq), 0);

    idle(2);
    check("pulse_q_empty", pulse_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_mc.md
Name:
timer_mc

Overview:
- Parametrised multi-channel programmable timer; successor to the 2-channel fixed timer.
- NCH identical channels, each with:
  - a prescaler,
  - a CNT_W-bit up-counter with compare,
  - one-shot/periodic mode,
  - optional cascade from the previous channel.
- Programmed through the same read/write/addr/wdata/rdata register port; drives per-channel tout pulses to the surrounding control logic.

Parameters:
- NCH, 4, number of channels (1..8).
- CNT_W, 8, counter/compare/data width (8..16).
- PRE_W, 4, prescaler width (PRE_W <= CNT_W).
- CMP_RST, 9, reset value of every CMP register.
- Derived localparam ADDR_W = clog2(NCH)+2; addr = {channel, reg[1:0]}.

Ports:
- clk  in  1  single clock (already decided).
- rst_n  in  1  asynchronous active-low reset (already decided).
- read  in  1  register read strobe.
- write  in  1  register write strobe.
- addr  in  ADDR_W  {ch, reg}.
- wdata  in  CNT_W  write data.
- rdata  out  CNT_W  read data.
- tout  out  NCH  per-channel expiry pulse, 1 clk wide.
- irq  out  1  combined interrupt (see Optional Feature).

Behaviour:
- Register map per channel:
  - reg0 CTRL: bit0 START, bit1 ONESHOT, bit2 CASCADE, bit6 EXP (status, write-1-to-clear), bit7 CLR (self-clearing, reads 0).
  - reg1 CMP.
  - reg2 PRE (low PRE_W bits).
  - reg3 CNT (read-only; writes ignored).
- Reset (async): CTRL=0, CMP=CMP_RST, PRE=0, counters=0, tout=0, irq=0. rdata=0 during reset.
- Writes take effect on the clk edge where write=1.
- Reads are combinational:
  - rdata is valid in the same cycle read=1.
  - rdata=0 when read=0, for an unmapped channel (ch>=NCH), or for unused bits.
  - read and write in the same cycle: rdata shows the pre-write value.
- Tick source:
  - Normal: prescaler pre_cnt counts 0..PRE while START=1; tick when pre_cnt==PRE, then pre_cnt=0. PRE=0 gives a tick every clk.
  - CASCADE=1 and ch>0: tick = registered expiry of ch-1; the prescaler is held at 0.
  - CASCADE on ch0 is ignored.
- On a tick with START=1:
  - cnt==CMP: cnt<=0, EXP<=1, tout[ch]=1 on the next cycle for exactly one cycle. If ONESHOT, START<=0.
  - Otherwise cnt<=cnt+1, wrapping 2^CNT_W-1 -> 0.
  - CMP=0 gives expiry on every tick.
- START=0: cnt and pre_cnt hold (pause); setting START again resumes from the held values.
- CLR write: cnt and pre_cnt <=0 that cycle, regardless of START.
  - CLR+START written together: the clear takes that cycle; counting starts on the next tick.
- CMP write while running: effective immediately. If the new CMP < cnt, the counter wraps through max before matching.
- EXP set and W1C in the same cycle: set wins.
- tout latency: compare match at edge N -> tout high during cycle N+1.
- Reset asserted mid-count: all state is zeroed asynchronously; no tout pulse is emitted.

Optional Feature:
- Macro TIMER_MC_IRQ_EN.
- Defined:
  - CTRL bit5 is IE.
  - irq is registered: irq = OR over ch of (EXP & IE).
  - irq stays high until every such EXP is cleared.
- Undefined:
  - bit5 reads 0 and writes to it are ignored.
  - irq is tied 0.

Decomposition:
- Package timer_mc_pkg holds:
  - register offsets (REG_CTRL=0, REG_CMP=1, REG_PRE=2, REG_CNT=3),
  - CTRL bit-position constants,
  - reset constants.
- Sub-module timer_mc_ch: one channel (registers, prescaler, counter, compare, tout, EXP), with cascade_in/expire_out ports.
- The top level generate-instantiates NCH channels and handles address decode, the rdata mux, and the irq OR.

Test Plan:
- Reset defaults: after rst_n release, read ch0 CMP -> 0x09, CTRL -> 0x00, CNT -> 0x00; tout=0 and irq=0 throughout.
- Periodic: ch0 PRE=0, CMP=9, CTRL=0x01 -> tout[0] pulses every 10 clk, 1 clk wide; EXP=1; write CTRL=0x41 -> EXP reads 0.
- Prescale + one-shot: ch1 PRE=3, CMP=4, CTRL=0x03 -> one tout[1] pulse 20 clk after start; START then reads 0; no further pulses.
- Cascade: ch0 PRE=0, CMP=9, periodic; ch1 CMP=9, CTRL=0x05 -> tout[1] every 100 clk, coinciding 1 cycle after every 10th tout[0].
- Pause/clear: stop ch0 at CNT=5 -> CNT holds 5 across 20 clk; write CTRL=0x81 -> CNT reads 0, next expiry 10 clk later.
- IRQ (TIMER_MC_IRQ_EN): ch2 CTRL=0x21, CMP=2 -> irq rises 1 clk after the first tout[2]; W1C on EXP in the same cycle as the next expiry -> EXP stays 1 and irq stays high.
